// File: rtl/mem_latency_shim.sv
// rtl/mem_latency_shim.sv - latency/backpressure shim between a core memory port and a zero-latency RAM
//
// Purpose: accepts core memory requests into a bounded read-response queue,
// performs RAM accesses in the accept cycle (writes byte-merged), and returns
// read data in order no earlier than LATENCY cycles after accept.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mem_req_*   (in)                core request: valid/rw/byteen/addr/data/tag
//   mem_req_ready (out)             request accepted when valid & ready
//   mem_rsp_valid/data/tag (out)    read response, held until mem_rsp_ready
//   mem_rsp_ready (in)              core takes the response
//   ram_en/wen/addr/wdata (out)     zero-latency RAM access
//   ram_rdata (in)                  combinational RAM read data for ram_addr
//   occupancy, busy (out)           queued read responses / nonzero flag

module mem_latency_shim #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 8,
    parameter int BYTEEN_W = 4,
    parameter int LATENCY  = 4,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_req_valid,
    input  logic                         mem_req_rw,
    input  logic [BYTEEN_W-1:0]          mem_req_byteen,
    input  logic [ADDR_W-1:0]            mem_req_addr,
    input  logic [DATA_W-1:0]            mem_req_data,
    input  logic [TAG_W-1:0]             mem_req_tag,
    output logic                         mem_req_ready,
    output logic                         mem_rsp_valid,
    output logic [DATA_W-1:0]            mem_rsp_data,
    output logic [TAG_W-1:0]             mem_rsp_tag,
    input  logic                         mem_rsp_ready,
    output logic                         ram_en,
    output logic                         ram_wen,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];

    logic acc;
    logic push;
    logic pop;
    logic head_due;

    // Outputs are forced to their idle values while reset is asserted, so a
    // reset in the middle of traffic hides queued responses immediately.
    assign occupancy     = reset ? '0 : occ_q;
    assign busy          = (occupancy != '0);
    assign mem_req_ready = (occupancy < DEPTH_OCC);

    assign acc  = mem_req_valid & mem_req_ready;
    assign push = acc & ~mem_req_rw;

    assign head_due      = (occ_q != '0) && (cnt_q[head_q] == '0);
    assign mem_rsp_valid = ~reset & head_due;
    assign mem_rsp_data  = mem_rsp_valid ? data_q[head_q] : '0;
    assign mem_rsp_tag   = mem_rsp_valid ? tag_q[head_q]  : '0;
    assign pop           = mem_rsp_valid & mem_rsp_ready;

    assign ram_en   = acc;
    assign ram_addr = mem_req_addr;
    assign ram_wen  = acc & mem_req_rw & (|mem_req_byteen);

    // Read-modify-write merge: unselected bytes keep the current RAM contents.
    always_comb begin
        ram_wdata = ram_rdata;
        for (int i = 0; i < BYTEEN_W; i++) begin
            if (mem_req_byteen[i]) begin
                ram_wdata[i*8 +: 8] = mem_req_data[i*8 +: 8];
            end
        end
    end

    // Every slot's timer runs down independently of its position, so an
    // entry stuck behind a stalled head is already due when it reaches it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
        end
        if (push) begin
            cnt_d[tail_q] = CNT_INIT;
        end
    end

    always_comb begin
        head_d = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d = push ? tail_q + PTR_W'(1) : tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Payload and timers need no reset: occupancy gates their visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_q[i] <= cnt_d[i];
        end
        if (push) begin
            data_q[tail_q] <= ram_rdata;
            tag_q[tail_q]  <= mem_req_tag;
        end
    end

endmodule

// File: tb/tb_mem_latency_shim.sv
// tb/tb_mem_latency_shim.sv - self-checking bench for mem_latency_shim

module tb_mem_latency_shim;

    localparam int LAT = 4;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid, mem_req_rw;
    logic [3:0]  mem_req_byteen;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [7:0]  mem_req_tag;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [7:0]  mem_rsp_tag;
    logic        mem_rsp_ready;
    logic        ram_en, ram_wen;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  occupancy;
    logic        busy;

    always #5 clk = ~clk;

    mem_latency_shim #(
        .DATA_W(32), .ADDR_W(32), .TAG_W(8), .BYTEEN_W(4), .LATENCY(LAT), .DEPTH(DEP)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .occupancy(occupancy), .busy(busy)
    );

    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (ram_wen) mem[ram_addr[7:2]] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr[7:2]];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        int          due;
    } ent_t;

    logic [31:0] ref_mem [64];
    ent_t        q[$];
    int          cyc;
    int          n_cmp;
    int          n_bad;

    logic [7:0]  pop_tags[$];
    int          pop_cycs[$];
    logic [31:0] pop_datas[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        logic        exp_ready, exp_busy, acc, hv, exp_wen, exp_valid;
        logic [2:0]  exp_occ;
        logic [31:0] exp_data, cur, merged;
        logic [7:0]  exp_tag;
        logic [5:0]  idx;
        #1;
        exp_occ   = 3'(q.size());
        exp_busy  = (q.size() != 0);
        exp_ready = (q.size() < DEP);
        hv        = (q.size() > 0) && (q[0].due <= cyc);
        exp_valid = hv;
        exp_data  = hv ? q[0].data : 32'h0;
        exp_tag   = hv ? q[0].tag  : 8'h0;
        acc       = mem_req_valid & exp_ready;
        check("occupancy", 32'(occupancy), 32'(exp_occ));
        check("busy", 32'(busy), 32'(exp_busy));
        check("req_ready", 32'(mem_req_ready), 32'(exp_ready));
        check("ram_en", 32'(ram_en), 32'(acc));
        check("rsp_valid", 32'(mem_rsp_valid), 32'(exp_valid));
        check("rsp_data", mem_rsp_data, exp_data);
        check("rsp_tag", 32'(mem_rsp_tag), 32'(exp_tag));
        idx     = mem_req_addr[7:2];
        cur     = ref_mem[idx];
        merged  = cur;
        exp_wen = 1'b0;
        if (mem_req_valid) begin
            for (int b = 0; b < 4; b++)
                if (mem_req_byteen[b]) merged[b*8 +: 8] = mem_req_data[b*8 +: 8];
            exp_wen = acc & mem_req_rw & (mem_req_byteen != 4'h0);
            check("ram_wen", 32'(ram_wen), 32'(exp_wen));
            check("ram_addr", ram_addr, mem_req_addr);
            if (mem_req_rw) check("ram_wdata", ram_wdata, merged);
        end
        if (mem_rsp_valid && mem_rsp_ready) begin
            pop_tags.push_back(mem_rsp_tag);
            pop_cycs.push_back(cyc);
            pop_datas.push_back(mem_rsp_data);
        end
        @(posedge clk);
        if (hv && mem_rsp_ready) void'(q.pop_front());
        if (acc && !mem_req_rw) q.push_back('{data: cur, tag: mem_req_tag, due: cyc + LAT});
        if (exp_wen) ref_mem[idx] = merged;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        mem_req_valid = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(mem_rsp_valid), 32'h0);
        check("rst_rsp_data", mem_rsp_data, 32'h0);
        check("rst_rsp_tag", 32'(mem_rsp_tag), 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_req_ready", 32'(mem_req_ready), 32'h1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        q.delete();
        reset = 1'b0;
    endtask

    task automatic set_idle();
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_byteen = 4'h0;
        mem_req_data   = 32'h0;
        mem_req_tag    = 8'h0;
    endtask

    task automatic set_read(input logic [31:0] addr, input logic [7:0] tag);
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b0;
        mem_req_addr   = addr;
        mem_req_byteen = 4'h0;
        mem_req_tag    = tag;
    endtask

    task automatic set_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b1;
        mem_req_addr   = addr;
        mem_req_byteen = be;
        mem_req_data   = data;
        mem_req_tag    = 8'h0;
    endtask

    task automatic idle_steps(input int n);
        set_idle();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int          t_acc;
        logic [2:0]  occ_before;
        logic [31:0] w;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        reset = 1'b1;
        bd_we = 1'b0;
        bd_idx = 6'd0;
        bd_data = 32'h0;
        mem_req_addr  = 32'h8000_0000;
        mem_rsp_ready = 1'b1;
        set_idle();
        @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            w = $urandom();
            if (i == 0) w = 32'h6F00_8004;
            if (i == 1) w = 32'h1122_3344;
            if (i == 2) w = 32'hDEAD_BEEF;
            bd_we = 1'b1; bd_idx = 6'(i); bd_data = w;
            ref_mem[i] = w;
            @(posedge clk);
            @(negedge clk);
        end
        bd_we = 1'b0;
        do_reset();
        idle_steps(1);

        set_read(32'h8000_0000, 8'h15);
        t_acc = cyc;
        pop_cycs.delete(); pop_tags.delete(); pop_datas.delete();
        step();
        idle_steps(7);
        check("t1_pops", 32'(pop_cycs.size()), 32'd1);
        if (pop_cycs.size() == 1) begin
            check("t1_latency", 32'(pop_cycs[0]), 32'(t_acc + LAT));
            check("t1_tag", 32'(pop_tags[0]), 32'h15);
            check("t1_data", pop_datas[0], 32'h6F00_8004);
        end

        pop_cycs.delete(); pop_tags.delete(); pop_datas.delete();
        set_write(32'h8000_0004, 4'b0011, 32'hAABB_CCDD);
        #1;
        check("t2_wdata", ram_wdata, 32'h1122_CCDD);
        check("t2_wen", 32'(ram_wen), 32'h1);
        step();
        idle_steps(6);
        check("t2_no_rsp", 32'(pop_cycs.size()), 32'd0);
        set_read(32'h8000_0004, 8'h42);
        step();
        idle_steps(6);
        check("t2_readback_n", 32'(pop_datas.size()), 32'd1);
        if (pop_datas.size() == 1) check("t2_readback", pop_datas[0], 32'h1122_CCDD);

        pop_cycs.delete(); pop_tags.delete(); pop_datas.delete();
        mem_rsp_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            set_read(32'h8000_0000 + 32'(k * 4), 8'(k));
            step();
        end
        set_idle();
        #1;
        check("t3_occ_full", 32'(occupancy), 32'd4);
        check("t3_ready_low", 32'(mem_req_ready), 32'h0);
        idle_steps(LAT);
        mem_rsp_ready = 1'b1;
        idle_steps(6);
        check("t3_pop_count", 32'(pop_tags.size()), 32'd4);
        if (pop_tags.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t3_order", 32'(pop_tags[k]), 32'(k + 1));
                check("t3_back_to_back", 32'(pop_cycs[k]), 32'(pop_cycs[0] + k));
            end
        end

        pop_cycs.delete(); pop_tags.delete(); pop_datas.delete();
        mem_rsp_ready = 1'b0;
        set_read(32'h8000_0008, 8'h22);
        step();
        idle_steps(LAT + 3);
        #1;
        check("t4_hold_valid", 32'(mem_rsp_valid), 32'h1);
        check("t4_hold_tag", 32'(mem_rsp_tag), 32'h22);
        check("t4_hold_data", mem_rsp_data, 32'hDEAD_BEEF);
        mem_rsp_ready = 1'b1;
        idle_steps(4);
        check("t4_one_pop", 32'(pop_tags.size()), 32'd1);

        pop_cycs.delete(); pop_tags.delete(); pop_datas.delete();
        set_read(32'h8000_0010, 8'h31);
        step();
        set_read(32'h8000_0014, 8'h32);
        step();
        do_reset();
        idle_steps(10);
        check("t5_no_stale", 32'(pop_tags.size()), 32'd0);

        occ_before = occupancy;
        set_write(32'h8000_0018, 4'b0000, 32'hFFFF_FFFF);
        #1;
        check("t6_ram_en", 32'(ram_en), 32'h1);
        check("t6_ram_wen", 32'(ram_wen), 32'h0);
        step();
        set_idle();
        #1;
        check("t6_occ", 32'(occupancy), 32'(occ_before));
        step();

        for (int k = 0; k < 400; k++) begin
            mem_req_valid  = ($urandom_range(0, 99) < 60);
            mem_req_rw     = ($urandom_range(0, 99) < 40);
            mem_req_addr   = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            mem_req_byteen = 4'($urandom());
            mem_req_data   = $urandom();
            mem_req_tag    = 8'($urandom());
            mem_rsp_ready  = ($urandom_range(0, 99) < 65);
            step();
        end
        mem_rsp_ready = 1'b1;
        idle_steps(LAT + DEP + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
